// File: rtl/count_match_pkg.sv
// Shared types and helpers for the count-match timer: sequencer state encoding,
// default geometry of the upstream mod-N counter, and a saturating increment.
package count_match_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MOD_MAX_DEF = 4;
    localparam int CNT_W_DEF   = 3;
    localparam int RPT_W_DEF   = 8;
    // Narrowest count bus able to carry the terminal value.
    localparam int CNT_W_MIN   = $clog2(MOD_MAX_DEF + 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/count_match_timer_if.sv
// Bus bundle between the timer and its environment. COUNT_MATCH_IRQ_EN adds the
// interrupt pair (irq/irq_clr); without it those signals do not exist.
interface count_match_timer_if
    import count_match_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RPT_W = RPT_W_DEF
);
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cmp_val;
    logic             cmp_load;
    logic             arm;
    logic             disarm;
    logic [RPT_W-1:0] repeat_n;
    logic             match_pulse;
    logic             wrap_pulse;
    logic             busy;
    logic             done;
    logic             cmp_err;
    logic [RPT_W-1:0] match_total;
`ifdef COUNT_MATCH_IRQ_EN
    logic             irq;
    logic             irq_clr;

    modport master (
        output count, cmp_val, cmp_load, arm, disarm, repeat_n, irq_clr,
        input  match_pulse, wrap_pulse, busy, done, cmp_err, match_total, irq
    );
    modport slave (
        input  count, cmp_val, cmp_load, arm, disarm, repeat_n, irq_clr,
        output match_pulse, wrap_pulse, busy, done, cmp_err, match_total, irq
    );
`else
    modport master (
        output count, cmp_val, cmp_load, arm, disarm, repeat_n,
        input  match_pulse, wrap_pulse, busy, done, cmp_err, match_total
    );
    modport slave (
        input  count, cmp_val, cmp_load, arm, disarm, repeat_n,
        output match_pulse, wrap_pulse, busy, done, cmp_err, match_total
    );
`endif
endinterface

// File: rtl/count_edge_detect.sv
// Tracks the previous count value, flags a change, and strobes one cycle after
// the counter rolls from its terminal value back to zero.
module count_edge_detect
    import count_match_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MOD_MAX = MOD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_i,
    output logic             new_val_o,
    output logic             wrap_pulse_o
);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MOD_MAX);

    logic [CNT_W-1:0] count_q;
    logic             wrap_q;
    logic             wrap_d;

    assign new_val_o = (count_i != count_q);
    // Only a terminal->zero step is a wrap; any other drop is an upstream reset.
    assign wrap_d    = (count_q == MAX_V) && (count_i == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_i;
            wrap_q  <= wrap_d;
        end
    end

    assign wrap_pulse_o = wrap_q;

endmodule

// File: rtl/count_match_timer.sv
// Compare-match sequencer on an upstream mod-N count: loadable compare register,
// armed/repeat/done FSM, saturating match total. Optional irq via COUNT_MATCH_IRQ_EN.
module count_match_timer
    import count_match_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MOD_MAX = MOD_MAX_DEF,
    parameter int RPT_W   = RPT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    count_match_timer_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(MOD_MAX);
    localparam logic [31:0]      TOTAL_MAX = 32'({RPT_W{1'b1}});

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             cmp_err_q, cmp_err_d;
    logic [RPT_W-1:0] remaining_q, remaining_d;
    logic [RPT_W-1:0] total_q, total_d;
    logic             match_q, match_d;
    logic             new_val;
    logic             hit;

    count_edge_detect #(
        .CNT_W   (CNT_W),
        .MOD_MAX (MOD_MAX)
    ) u_edge (
        .clk          (clk),
        .rst          (rst),
        .count_i      (bus.count),
        .new_val_o    (new_val),
        .wrap_pulse_o (bus.wrap_pulse)
    );

    // A load takes effect next cycle, so a same-cycle hit still sees the old value.
    assign hit = new_val && (bus.count == cmp_q);

    always_comb begin
        cmp_d     = cmp_q;
        cmp_err_d = cmp_err_q;
        if (bus.cmp_load) begin
            if (bus.cmp_val <= MAX_V) cmp_d = bus.cmp_val;
            else                      cmp_err_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        match_d     = hit && (state_q == ARMED);
        total_d     = match_d ? RPT_W'(sat_inc(32'(total_q), TOTAL_MAX)) : total_q;
        if (bus.disarm) begin
            state_d     = IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.arm) begin
                        state_d     = ARMED;
                        remaining_d = bus.repeat_n;
                    end
                end
                ARMED: begin
                    // remaining==0 means continuous: never decremented, never done.
                    if (hit && remaining_q == RPT_W'(1)) begin
                        state_d     = DONE;
                        remaining_d = '0;
                    end else if (hit && remaining_q != '0) begin
                        remaining_d = remaining_q - RPT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmp_q       <= '0;
            cmp_err_q   <= 1'b0;
            remaining_q <= '0;
            total_q     <= '0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmp_q       <= cmp_d;
            cmp_err_q   <= cmp_err_d;
            remaining_q <= remaining_d;
            total_q     <= total_d;
            match_q     <= match_d;
        end
    end

    assign bus.match_pulse = match_q;
    assign bus.busy        = (state_q == ARMED);
    assign bus.done        = (state_q == DONE);
    assign bus.cmp_err     = cmp_err_q;
    assign bus.match_total = total_q;

`ifdef COUNT_MATCH_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if ((state_d == DONE && state_q != DONE) || (cmp_err_d && !cmp_err_q)) irq_d = 1'b1;
        else if (bus.irq_clr)                                                   irq_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_count_match_timer.sv
// Directed-plus-random bench for count_match_timer; every cycle the DUT outputs are
// compared with a behavioural model built from the event rules of the block.
module tb_count_match_timer;
    import count_match_pkg::*;

    localparam int CNT_W   = 3;
    localparam int MOD_MAX = 4;
    localparam int RPT_W   = 8;
    localparam int TOT_MAX = (1 << RPT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    count_match_timer_if #(.CNT_W(CNT_W), .RPT_W(RPT_W)) bus ();

    count_match_timer #(
        .CNT_W   (CNT_W),
        .MOD_MAX (MOD_MAX),
        .RPT_W   (RPT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: mode 0=idle, 1=armed, 2=done; left = matches still owed.
    int m_prev = 0, m_cmp = 0, m_err = 0, m_mode = 0, m_left = 0, m_total = 0, m_irq = 0;
    bit exp_match = 0, exp_wrap = 0;

    int cur_count = 0;
    int hold_pct  = 0;
    bit glitch    = 0;
    int pulses    = 0;
    int wraps     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int c;
        bit hit;
        int old_mode;
        int old_err;
        if (rst) begin
            m_prev = 0; m_cmp = 0; m_err = 0; m_mode = 0; m_left = 0;
            m_total = 0; m_irq = 0; exp_match = 0; exp_wrap = 0;
        end else begin
            c        = int'(bus.count);
            hit      = (c != m_prev) && (c == m_cmp);
            old_mode = m_mode;
            old_err  = m_err;
            exp_wrap  = (m_prev == MOD_MAX) && (c == 0);
            exp_match = hit && (m_mode == 1);
            if (exp_match && m_total < TOT_MAX) m_total++;
            if (bus.cmp_load) begin
                if (int'(bus.cmp_val) <= MOD_MAX) m_cmp = int'(bus.cmp_val);
                else                              m_err = 1;
            end
            if (bus.disarm) m_mode = 0;
            else if (bus.arm && m_mode != 1) begin
                m_mode = 1;
                m_left = int'(bus.repeat_n);
            end else if (exp_match && m_left > 0) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
`ifdef COUNT_MATCH_IRQ_EN
            if ((m_mode == 2 && old_mode != 2) || (m_err == 1 && old_err == 0)) m_irq = 1;
            else if (bus.irq_clr) m_irq = 0;
`endif
            m_prev = c;
        end
    endtask

    task automatic compare_all();
        check("match_pulse", bus.match_pulse, exp_match);
        check("wrap_pulse", bus.wrap_pulse, exp_wrap);
        check("busy", bus.busy, m_mode == 1);
        check("done", bus.done, m_mode == 2);
        check("cmp_err", bus.cmp_err, m_err);
        check("match_total", bus.match_total, m_total);
`ifdef COUNT_MATCH_IRQ_EN
        check("irq", bus.irq, m_irq);
`endif
        if (bus.match_pulse === 1'b1) pulses++;
        if (bus.wrap_pulse === 1'b1) wraps++;
    endtask

    // One clock: new count at negedge, model update at posedge, compare just after.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if ($urandom_range(99) < hold_pct) begin
                cur_count = cur_count;
            end else if (glitch && cur_count > 0 && $urandom_range(9) == 0) begin
                cur_count = 0;
            end else begin
                cur_count = (cur_count == MOD_MAX) ? 0 : cur_count + 1;
            end
            bus.count = CNT_W'(cur_count);
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    task automatic load_cmp(input int v);
        bus.cmp_val  = CNT_W'(v);
        bus.cmp_load = 1'b1;
        cyc(1);
        bus.cmp_load = 1'b0;
    endtask

    task automatic do_arm(input int rpt);
        bus.repeat_n = RPT_W'(rpt);
        bus.arm      = 1'b1;
        cyc(1);
        bus.arm      = 1'b0;
    endtask

    initial begin
        bus.count = '0; bus.cmp_val = '0; bus.cmp_load = 1'b0;
        bus.arm = 1'b0; bus.disarm = 1'b0; bus.repeat_n = '0;
`ifdef COUNT_MATCH_IRQ_EN
        bus.irq_clr = 1'b0;
`endif
        // Reset state
        rst = 1'b1;
        cyc(3);
        check("rst_match_total", bus.match_total, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        cur_count = 0;
        $display("step reset: outputs idle");

        // 1: wrap detection over a clean 0..4 sequence
        wraps = 0;
        cyc(20);
        check("t1_wraps", wraps, 4);
        $display("step wrap: %0d wraps in 20 cycles", wraps);

        // 2: three matches on count==2, then done
        load_cmp(2);
        do_arm(3);
        pulses = 0;
        for (int k = 0; k < 60 && bus.done !== 1'b1; k++) cyc(1);
        check("t2_pulses", pulses, 3);
        check("t2_done", bus.done, 1);
        check("t2_busy", bus.busy, 0);
        $display("step repeat3: %0d pulses done=%0b", pulses, bus.done);

        // 3: continuous mode, then disarm stops pulses
        do_arm(0);
        pulses = 0;
        cyc(50);
        check("t3_pulses", pulses, 10);
        check("t3_done", bus.done, 0);
        bus.disarm = 1'b1;
        cyc(1);
        bus.disarm = 1'b0;
        pulses = 0;
        cyc(15);
        check("t3_after_disarm", pulses, 0);
        check("t3_busy", bus.busy, 0);
        $display("step continuous: disarmed, busy=%0b", bus.busy);

        // 4: out-of-range load rejected, valid load moves the match point
        do_arm(0);
        load_cmp(6);
        check("t4_cmp_err", bus.cmp_err, 1);
        pulses = 0;
        cyc(10);
        check("t4_old_cmp_pulses", pulses, 2);
`ifdef COUNT_MATCH_IRQ_EN
        check("t4_irq_err", bus.irq, 1);
        bus.irq_clr = 1'b1;
        cyc(1);
        bus.irq_clr = 1'b0;
        check("t4_irq_clr", bus.irq, 0);
`endif
        load_cmp(3);
        pulses = 0;
        cyc(10);
        check("t4_new_cmp_pulses", pulses, 2);
        $display("step cmp_load: err=%0b pulses=%0d", bus.cmp_err, pulses);

        // 5: held count hits once; arm+disarm together lands in IDLE
        pulses = 0;
        for (int k = 0; k < 10 && cur_count != 3; k++) cyc(1);
        hold_pct = 100;
        cyc(5);
        check("t5_held_pulses", pulses, 1);
        hold_pct = 0;
        bus.arm = 1'b1; bus.disarm = 1'b1;
        cyc(1);
        bus.arm = 1'b0; bus.disarm = 1'b0;
        check("t5_arm_disarm_busy", bus.busy, 0);
        check("t5_arm_disarm_done", bus.done, 0);
        $display("step hold: pulses=%0d", pulses);

        // 6: reset mid-sequence, then irq on done
        do_arm(3);
        pulses = 0;
        for (int k = 0; k < 20 && pulses < 1; k++) cyc(1);
        rst = 1'b1;
        cyc(1);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_total", bus.match_total, 0);
        check("t6_rst_err", bus.cmp_err, 0);
        cyc(1);
        rst = 1'b0;
        load_cmp(2);
        do_arm(1);
        for (int k = 0; k < 20 && bus.done !== 1'b1; k++) cyc(1);
        check("t6_done", bus.done, 1);
`ifdef COUNT_MATCH_IRQ_EN
        check("t6_irq_set", bus.irq, 1);
        bus.irq_clr = 1'b1;
        cyc(1);
        bus.irq_clr = 1'b0;
        check("t6_irq_clr", bus.irq, 0);
`endif
        $display("step reset_mid: done=%0b", bus.done);

        // Random traffic against the model
        hold_pct = 20;
        glitch   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bus.arm      = ($urandom_range(99) < 8);
            bus.disarm   = ($urandom_range(99) < 4);
            bus.cmp_load = ($urandom_range(99) < 6);
            bus.cmp_val  = CNT_W'($urandom_range(7));
            bus.repeat_n = RPT_W'($urandom_range(4));
`ifdef COUNT_MATCH_IRQ_EN
            bus.irq_clr  = ($urandom_range(99) < 10);
`endif
            rst = ($urandom_range(199) == 0);
            cyc(1);
        end
        bus.arm = 1'b0; bus.disarm = 1'b0; bus.cmp_load = 1'b0; rst = 1'b0;
`ifdef COUNT_MATCH_IRQ_EN
        bus.irq_clr = 1'b0;
`endif
        $display("step random: 600 cycles, total=%0d", bus.match_total);

        // match_total saturation
        hold_pct = 0;
        glitch   = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        load_cmp(0);
        do_arm(0);
        cyc(1320);
        check("sat_total", bus.match_total, TOT_MAX);
        $display("step saturate: total=%0d", bus.match_total);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
